char_pwm_decoder: RTL and testbench



---
 rtl/char_pwm_pkg.sv | 19 +
 rtl/pwm_edge_sync.sv | 30 +++
 rtl/char_pwm_decoder.sv | 168 ++++++++++++++++
 tb/tb_char_pwm_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/char_pwm_pkg.sv
// Shared types and encode/decode constants for the character PWM generator and decoder.
package char_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_t;

  typedef logic [1:0] char_t;

  localparam int PERIOD_DEF = 16;

  // Code k occupies high times [k*PERIOD/4, (k+1)*PERIOD/4), so decode is a right shift.
  function automatic int bin_shift(input int period);
    return $clog2(period / 4);
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser for an asynchronous PWM line with registered rise/fall strobes.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1;
  logic ds;
  logic ds_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      ds   <= 1'b0;
      ds_q <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      ds   <= s1;
      ds_q <= ds;
      rise <= ds & ~ds_q;
      fall <= ~ds & ds_q;
    end
  end

endmodule

// File: rtl/char_pwm_decoder.sv
// Measures high time and period of each PWM frame and decodes the 2-bit character code.
// char_valid is a one-cycle strobe with no back-pressure; frame_char is meaningful only while it is high.
module char_pwm_decoder
  import char_pwm_pkg::*;
#(
  parameter int PERIOD      = PERIOD_DEF,
  parameter int TOL         = 1,
  parameter int MATCH_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit,
  output logic [1:0] char_out,
  output logic       char_valid,
  output logic [1:0] frame_char,
  output logic       char_change,
  output logic       locked,
  output logic       err
);

  localparam int CW = $clog2(2 * PERIOD + 1);
  localparam int RW = $clog2(MATCH_COUNT + 1);
  localparam int SHIFT = bin_shift(PERIOD);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_TMO = CW'(2 * PERIOD);
  localparam logic [CW-1:0] PER_LO  = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] PER_HI  = CW'(PERIOD + TOL);
  localparam logic [RW-1:0] RUN_MAX = RW'(MATCH_COUNT);

  logic rise;
  logic fall;

  pwm_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (digit),
    .rise (rise),
    .fall (fall)
  );

  pwm_state_t    state, state_nxt;
  logic [CW-1:0] hi_cnt, hi_nxt;
  logic [CW-1:0] per_cnt, per_nxt;
  logic [CW-1:0] hi_bin;
  logic [RW-1:0] run, run_nxt;
  char_t         prev_code;
  char_t         code;
  logic          in_tol;
  logic          timeout;
  logic          frame_close;
  logic          ev_valid;
  logic          ev_err;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign in_tol = (per_cnt >= PER_LO) && (per_cnt <= PER_HI);
  assign hi_bin = hi_cnt >> SHIFT;
  assign code   = (hi_bin > CW'(3)) ? 2'd3 : hi_bin[1:0];

  // An edge always wins over a timeout landing in the same cycle.
  assign timeout = (per_cnt == CNT_TMO) &&
                   (((state == ST_HIGH) && !fall) || ((state == ST_LOW) && !rise));
  assign frame_close = (state == ST_LOW) && rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hi_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      state   <= state_nxt;
      hi_cnt  <= hi_nxt;
      per_cnt <= per_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_cnt;
    per_nxt   = per_cnt;
    case (state)
      ST_IDLE: begin
        hi_nxt  = '0;
        per_nxt = '0;
        if (rise) begin
          state_nxt = ST_HIGH;
          hi_nxt    = CW'(1);
          per_nxt   = CW'(1);
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_nxt = ST_LOW;
          per_nxt   = sat_inc(per_cnt);
        end else if (timeout) begin
          state_nxt = ST_IDLE;
          hi_nxt    = '0;
          per_nxt   = '0;
        end else begin
          hi_nxt  = sat_inc(hi_cnt);
          per_nxt = sat_inc(per_cnt);
        end
      end
      ST_LOW: begin
        // The closing rise is also the first high cycle of the next frame.
        if (rise) begin
          state_nxt = ST_HIGH;
          hi_nxt    = CW'(1);
          per_nxt   = CW'(1);
        end else if (timeout) begin
          state_nxt = ST_IDLE;
          hi_nxt    = '0;
          per_nxt   = '0;
        end else begin
          per_nxt = sat_inc(per_cnt);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hi_nxt    = '0;
        per_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    ev_valid = frame_close && in_tol;
    ev_err   = (frame_close && !in_tol) || timeout;
    run_nxt  = RW'(1);
    if ((run != '0) && (code == prev_code)) begin
      run_nxt = (run >= RUN_MAX) ? RUN_MAX : run + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      char_out    <= 2'd0;
      char_valid  <= 1'b0;
      frame_char  <= 2'd0;
      char_change <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      run         <= '0;
      prev_code   <= 2'd0;
    end else begin
      char_valid  <= ev_valid;
      err         <= ev_err;
      char_change <= 1'b0;
      if (ev_valid) begin
        frame_char <= code;
        prev_code  <= code;
        run        <= run_nxt;
        locked     <= 1'b1;
        if ((run_nxt == RUN_MAX) && (code != char_out)) begin
          char_out    <= code;
          char_change <= 1'b1;
        end
      end
      if (ev_err) begin
        run    <= '0;
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_char_pwm_decoder.sv
// Directed bench for char_pwm_decoder: frame table plus timeout and reset sequences.
`timescale 1ns/1ps
module tb_char_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit = 1'b0;
  logic [1:0] char_out;
  logic       char_valid;
  logic [1:0] frame_char;
  logic       char_change;
  logic       locked;
  logic       err;

  char_pwm_decoder #(.PERIOD(16), .TOL(1), .MATCH_COUNT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit       (digit),
    .char_out    (char_out),
    .char_valid  (char_valid),
    .frame_char  (frame_char),
    .char_change (char_change),
    .locked      (locked),
    .err         (err)
  );

  always #5 clk = ~clk;

  // One row per frame; the expectations describe what closing that frame produces.
  typedef struct {
    int         hi;
    int         lo;
    bit         v;
    logic [1:0] code;
    bit         e;
    bit         chg;
    logic [1:0] out;
    bit         lk;
  } vec_t;

  vec_t       vt [0:25];
  logic [1:0] exp_q [$];
  int         total = 0;
  int         bad = 0;
  int         win_valid = 0;
  int         win_err = 0;
  int         win_chg = 0;

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: sample just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (char_valid) begin
      win_valid++;
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_valid", 1, 0);
      end else begin
        check_val("sb_frame_char", int'(frame_char), int'(exp_q.pop_front()));
      end
    end
    if (err) win_err++;
    if (char_change) win_chg++;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_win();
    win_valid = 0;
    win_err   = 0;
    win_chg   = 0;
  endtask

  task automatic run_frame(input int hi, input int lo);
    digit = 1'b1;
    wait_neg(hi);
    digit = 1'b0;
    wait_neg(lo);
  endtask

  task automatic check_row(input int i);
    check_val($sformatf("row%0d_valid", i), win_valid, int'(vt[i].v));
    check_val($sformatf("row%0d_err", i), win_err, int'(vt[i].e));
    check_val($sformatf("row%0d_change", i), win_chg, int'(vt[i].chg));
    check_val($sformatf("row%0d_char_out", i), int'(char_out), int'(vt[i].out));
    check_val($sformatf("row%0d_locked", i), int'(locked), int'(vt[i].lk));
  endtask

  task automatic check_quiet(input string tag, input int out0);
    check_val({tag, "_valid"}, win_valid, 0);
    check_val({tag, "_err"}, win_err, 0);
    check_val({tag, "_change"}, win_chg, 0);
    check_val({tag, "_char_out"}, int'(char_out), out0);
    check_val({tag, "_locked"}, int'(locked), 0);
  endtask

  // Leaves digit high, so the DUT is mid-HIGH on return.
  task automatic run_seq(input int first, input int last, input int out0);
    for (int i = first; i <= last; i++) begin
      if (i > first && vt[i-1].v) exp_q.push_back(vt[i-1].code);
      clear_win();
      run_frame(vt[i].hi, vt[i].lo);
      if (i == first) check_quiet($sformatf("row%0d_first", i), out0);
      else check_row(i - 1);
    end
    if (vt[last].v) exp_q.push_back(vt[last].code);
    clear_win();
    digit = 1'b1;
    wait_neg(8);
    check_row(last);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_char_out"}, int'(char_out), 0);
    check_val({tag, "_char_valid"}, int'(char_valid), 0);
    check_val({tag, "_frame_char"}, int'(frame_char), 0);
    check_val({tag, "_char_change"}, int'(char_change), 0);
    check_val({tag, "_locked"}, int'(locked), 0);
    check_val({tag, "_err"}, int'(err), 0);
  endtask

  task automatic do_reset();
    digit = 1'b0;
    rst   = 1'b1;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(3);
  endtask

  initial begin
    //             hi  lo  v  code e  chg out lk
    vt[0]  = '{10,  6, 1, 2'd2, 0, 0, 2'd0, 1};
    vt[1]  = '{10,  6, 1, 2'd2, 0, 1, 2'd2, 1};
    vt[2]  = '{10,  6, 1, 2'd2, 0, 0, 2'd2, 1};
    vt[3]  = '{10,  6, 1, 2'd2, 0, 0, 2'd2, 1};
    vt[4]  = '{ 2, 14, 1, 2'd0, 0, 0, 2'd2, 1};
    vt[5]  = '{ 2, 14, 1, 2'd0, 0, 1, 2'd0, 1};
    vt[6]  = '{14,  2, 1, 2'd3, 0, 0, 2'd0, 1};
    vt[7]  = '{14,  2, 1, 2'd3, 0, 1, 2'd3, 1};
    vt[8]  = '{ 6, 10, 1, 2'd1, 0, 0, 2'd3, 1};
    vt[9]  = '{ 6, 10, 1, 2'd1, 0, 1, 2'd1, 1};
    vt[10] = '{10,  6, 1, 2'd2, 0, 0, 2'd1, 1};
    vt[11] = '{ 6, 13, 0, 2'd0, 1, 0, 2'd1, 0};
    vt[12] = '{10,  6, 1, 2'd2, 0, 0, 2'd1, 1};
    vt[13] = '{10,  6, 1, 2'd2, 0, 1, 2'd2, 1};
    vt[14] = '{10,  5, 1, 2'd2, 0, 0, 2'd2, 1};
    vt[15] = '{10,  7, 1, 2'd2, 0, 0, 2'd2, 1};
    vt[16] = '{10,  4, 0, 2'd0, 1, 0, 2'd2, 0};
    vt[17] = '{10,  8, 0, 2'd0, 1, 0, 2'd2, 0};
    vt[18] = '{10,  6, 1, 2'd2, 0, 0, 2'd2, 1};
    vt[19] = '{14,  2, 1, 2'd3, 0, 0, 2'd0, 1};
    vt[20] = '{14,  2, 1, 2'd3, 0, 1, 2'd3, 1};
    vt[21] = '{ 6, 10, 1, 2'd1, 0, 0, 2'd3, 1};
    vt[22] = '{ 6, 10, 1, 2'd1, 0, 1, 2'd1, 1};
    vt[23] = '{ 2,  6, 0, 2'd0, 1, 0, 2'd0, 0};
    vt[24] = '{10,  6, 1, 2'd2, 0, 0, 2'd0, 1};
    vt[25] = '{10,  6, 1, 2'd2, 0, 1, 2'd2, 1};

    wait_neg(3);
    check_zero_outputs("reset");
    rst = 1'b0;
    wait_neg(3);

    // Steady char 2, code pairs, bad period, tolerance edges.
    run_seq(0, 18, 0);
    do_reset();

    // Stuck high: one timeout, no decode, the fall in IDLE is ignored.
    clear_win();
    digit = 1'b1;
    wait_neg(40);
    check_val("stuck_high_err", win_err, 1);
    check_val("stuck_high_valid", win_valid, 0);
    check_val("stuck_high_locked", int'(locked), 0);
    clear_win();
    digit = 1'b0;
    wait_neg(10);
    check_val("idle_fall_err", win_err, 0);
    run_seq(19, 20, 0);

    // Stuck low after the rise that ended the tail window.
    clear_win();
    digit = 1'b0;
    wait_neg(40);
    check_val("stuck_low_err", win_err, 1);
    check_val("stuck_low_valid", win_valid, 0);
    check_val("stuck_low_locked", int'(locked), 0);
    check_val("stuck_low_char_out", int'(char_out), 3);
    run_seq(21, 22, 3);

    // Reset for one cycle while the FSM is mid-HIGH.
    check_val("pre_reset_locked", int'(locked), 1);
    rst = 1'b1;
    wait_neg(1);
    check_zero_outputs("mid_reset");
    rst = 1'b0;
    wait_neg(1);
    check_zero_outputs("post_reset");
    run_seq(23, 25, 0);

    digit = 1'b0;
    wait_neg(6);
    check_val("sb_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
